// File: rtl/ram_rmw_ctrl.sv
// Read-modify-write engine for a pipelined two-port RAM of statistics
// counters. After reset the whole RAM is zero-filled, then one request per
// cycle is accepted: the counter is read, the old value is taken from the
// hazard-corrected read-refresh stage, and the updated value is written back.
module ram_rmw_ctrl #(
    parameter int RAM_PIPE_STAGE = 2,
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  ram_rd,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_wr,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_wmask,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata_proc
);

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_CLEAR = 2'b01,
        OP_READ  = 2'b10,
        OP_SET   = 2'b11
    } op_t;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    // One slot of the op pipeline that tracks a request while its read is
    // in flight through the RAM.
    typedef struct packed {
        logic                  valid;
        op_t                   op;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_t                  state_q;
    state_t                  state_d;
    logic [ADDR_WIDTH-1:0]   init_cnt_q;
    logic [ADDR_WIDTH-1:0]   init_cnt_d;
    stage_t                  pipe_q [RAM_PIPE_STAGE];
    stage_t                  tail;
    logic                    accept;
    logic [DATA_WIDTH:0]     sum;
    logic [DATA_WIDTH-1:0]   result;

    logic                    req_ready_d;
    logic                    init_done_d;
    logic                    rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_data_d;
    logic                    ram_wr_d;
    logic [ADDR_WIDTH-1:0]   ram_waddr_d;
    logic [DATA_WIDTH-1:0]   ram_wdata_d;

    // The read is launched in the same cycle the request is accepted.
    assign accept    = req_valid & req_ready;
    assign ram_rd    = accept;
    assign ram_raddr = req_addr;
    assign ram_wmask = '1;

    // The last pipeline slot lines up with ram_rdata_proc for its request.
    assign tail = pipe_q[RAM_PIPE_STAGE-1];

    // Apply the operation to the old value; ADD saturates at all ones.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sum    = {1'b0, ram_rdata_proc} + {1'b0, tail.data};
        result = '0;
        unique case (tail.op)
            OP_ADD:   result = sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
            OP_CLEAR: result = '0;
            OP_SET:   result = tail.data;
            default:  result = ram_rdata_proc;
        endcase
    end

    // Next state and next registered outputs for the INIT/RUN controller.
    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        req_ready_d = 1'b0;
        init_done_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data;
        ram_wr_d    = 1'b0;
        ram_waddr_d = ram_waddr;
        ram_wdata_d = ram_wdata;

        unique case (state_q)
            ST_INIT: begin
                ram_wr_d    = 1'b1;
                ram_waddr_d = init_cnt_q;
                ram_wdata_d = '0;
                init_cnt_d  = init_cnt_q + ADDR_WIDTH'(1);
                if (init_cnt_q == ADDR_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                req_ready_d = 1'b1;
                init_done_d = 1'b1;
                if (tail.valid) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = ram_rdata_proc;
                    if (tail.op != OP_READ) begin
                        ram_wr_d    = 1'b1;
                        ram_waddr_d = tail.addr;
                        ram_wdata_d = result;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Controller state and registered outputs; reset drops everything.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            req_ready  <= 1'b0;
            init_done  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            ram_wr     <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            req_ready  <= req_ready_d;
            init_done  <= init_done_d;
            rsp_valid  <= rsp_valid_d;
            rsp_data   <= rsp_data_d;
            ram_wr     <= ram_wr_d;
            ram_waddr  <= ram_waddr_d;
            ram_wdata  <= ram_wdata_d;
        end
    end

    // Valid-tagged shift pipeline that carries op, addr and data alongside
    // the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the pipeline is a handful of flops, not a memory array, so the
        // whole slot is reset; only the valid bits matter functionally.
        if (!rst_n) begin
            for (int i = 0; i < RAM_PIPE_STAGE; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: accept, op: op_t'(req_op), addr: req_addr, data: req_data};
            for (int i = 1; i < RAM_PIPE_STAGE; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_ram_rmw_ctrl.sv
// Directed bench for ram_rmw_ctrl. A behavioural RAM plus read-refresh stage
// supplies ram_rdata_proc: reads return data RAM_PIPE_STAGE cycles later and
// see any write landing in that same cycle.
module tb_ram_rmw_ctrl;

    localparam int P  = 2;
    localparam int AW = 4;
    localparam int DW = 8;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_SET   = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = 2'b00;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          ram_rd;
    logic [AW-1:0] ram_raddr;
    logic          ram_wr;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wmask;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata_proc;

    int n_cmp  = 0;
    int n_fail = 0;

    ram_rmw_ctrl #(
        .RAM_PIPE_STAGE(P),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .init_done     (init_done),
        .ram_rd        (ram_rd),
        .ram_raddr     (ram_raddr),
        .ram_wr        (ram_wr),
        .ram_waddr     (ram_waddr),
        .ram_wmask     (ram_wmask),
        .ram_wdata     (ram_wdata),
        .ram_rdata_proc(ram_rdata_proc)
    );

    always #5 clk = ~clk;

    // RAM model: starts with junk so a missing zero-fill is visible.
    logic [DW-1:0] mem [2**AW] = '{default: 8'hEE};
    logic          rd_v [P] = '{default: 1'b0};
    logic [AW-1:0] rd_a [P] = '{default: '0};

    // Writes land at the clock edge ending the write cycle.
    always @(posedge clk) begin
        if (ram_wr) mem[ram_waddr] <= ram_wdata;
    end

    // Read address delay line matching the RAM read latency.
    always @(posedge clk) begin
        rd_v[0] <= ram_rd;
        rd_a[0] <= ram_raddr;
        for (int i = 1; i < P; i++) begin
            rd_v[i] <= rd_v[i-1];
            rd_a[i] <= rd_a[i-1];
        end
    end

    // Refresh stage: a write in the delivery cycle itself is forwarded.
    assign ram_rdata_proc = !rd_v[P-1] ? 8'hA5 :
                            (ram_wr && ram_waddr == rd_a[P-1]) ? ram_wdata : mem[rd_a[P-1]];

    // Observed response/write bundle: {rsp_valid, rsp_data, ram_wr, ram_waddr, ram_wdata}.
    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
    } obs_t;

    function automatic obs_t sample();
        return obs_t'({rsp_valid, rsp_data, ram_wr, ram_waddr, ram_wdata});
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_op    = OP_SET;
        req_addr  = 4'hF;
        req_data  = 8'h5A;
        #1;
    endtask

    // Zero-fill sequence after reset release: 16 writes, then ready.
    task automatic run_zero_fill(input string tag);
        obs_t got;
        obs_t exp;
        rst_n = 1'b1;
        drive(OP_READ, 4'd9, 8'd0);
        for (int i = 0; i < 2**AW; i++) begin
            step();
            got = sample();
            exp = '{v: 1'b0, d: 8'd0, wr: 1'b1, a: AW'(i), wd: 8'd0};
            n_cmp++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL %s_fill[%0d]: got %h want %h (v,d,wr,a,wd)", tag, i, got, exp);
            end
            n_cmp++;
            if ({req_ready, init_done, ram_rd} !== 3'b000) begin
                n_fail++;
                $display("FAIL %s_fill_ctl[%0d]: got ready,done,rd=%b want 000", tag, i,
                         {req_ready, init_done, ram_rd});
            end
        end
        idle();
        step();
        n_cmp++;
        if ({req_ready, init_done, ram_wr, rsp_valid} !== 4'b1100) begin
            n_fail++;
            $display("FAIL %s_ready: got ready,done,wr,rv=%b want 1100", tag,
                     {req_ready, init_done, ram_wr, rsp_valid});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        step();
        step();
        n_cmp++;
        if ({req_ready, init_done, rsp_valid, rsp_data, ram_wr, ram_waddr, ram_wdata, ram_wmask, ram_rd}
            !== {1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 4'd0, 8'd0, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got rdy=%b done=%b rv=%b rd=%0d wr=%b wa=%0d wd=%0d wm=%h rd_en=%b want all 0, wm=ff",
                     req_ready, init_done, rsp_valid, rsp_data, ram_wr, ram_waddr, ram_wdata, ram_wmask, ram_rd);
        end
        run_zero_fill("init");
    endtask

    task automatic test_single_add();
        obs_t got;
        drive(OP_ADD, 4'd3, 8'd5);
        n_cmp++;
        if ({ram_rd, ram_raddr} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL add_rd: got rd=%b raddr=%0d want rd=1 raddr=3", ram_rd, ram_raddr);
        end
        step();
        idle();
        for (int c = 1; c <= 2; c++) begin
            n_cmp++;
            if ({rsp_valid, ram_wr} !== 2'b00) begin
                n_fail++;
                $display("FAIL add_early[%0d]: got rv,wr=%b want 00", c, {rsp_valid, ram_wr});
            end
            step();
        end
        got = sample();
        n_cmp++;
        if (got !== obs_t'{v: 1'b1, d: 8'd0, wr: 1'b1, a: 4'd3, wd: 8'd5}) begin
            n_fail++;
            $display("FAIL add_rsp: got %h want v=1 d=0 wr=1 a=3 wd=5", got);
        end
        step();
        n_cmp++;
        if ({rsp_valid, ram_wr, rsp_data} !== {1'b0, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL add_idle: got rv=%b wr=%b rd=%0d want 0 0 0(hold)", rsp_valid, ram_wr, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        obs_t got;
        obs_t exp;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                drive(OP_ADD, 4'd7, 8'd1);
                n_cmp++;
                if ({ram_rd, ram_raddr} !== {1'b1, 4'd7}) begin
                    n_fail++;
                    $display("FAIL b2b_rd[%0d]: got rd=%b raddr=%0d want 1 7", c, ram_rd, ram_raddr);
                end
            end else begin
                idle();
            end
            if (c >= 3) begin
                got = sample();
                exp = '{v: 1'b1, d: DW'(c - 3), wr: 1'b1, a: 4'd7, wd: DW'(c - 2)};
                n_cmp++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got %h want %h (v,d,wr,a,wd)", c - 3, got, exp);
                end
            end
            step();
        end
        n_cmp++;
        if ({rsp_valid, ram_wr, rsp_data} !== {1'b0, 1'b0, 8'd3}) begin
            n_fail++;
            $display("FAIL b2b_idle: got rv=%b wr=%b rd=%0d want 0 0 3", rsp_valid, ram_wr, rsp_data);
        end
    endtask

    task automatic test_saturation();
        obs_t got;
        drive(OP_SET, 4'd2, 8'd250);
        step();
        drive(OP_ADD, 4'd2, 8'd10);
        step();
        idle();
        step();
        got = sample();
        n_cmp++;
        if (got !== obs_t'{v: 1'b1, d: 8'd0, wr: 1'b1, a: 4'd2, wd: 8'd250}) begin
            n_fail++;
            $display("FAIL sat_set: got %h want v=1 d=0 wr=1 a=2 wd=250", got);
        end
        step();
        got = sample();
        n_cmp++;
        if (got !== obs_t'{v: 1'b1, d: 8'd250, wr: 1'b1, a: 4'd2, wd: 8'd255}) begin
            n_fail++;
            $display("FAIL sat_add: got %h want v=1 d=250 wr=1 a=2 wd=255", got);
        end
        step();
    endtask

    task automatic test_mixed_ops();
        obs_t got;
        drive(OP_CLEAR, 4'd2, 8'd77);
        step();
        drive(OP_READ, 4'd2, 8'd99);
        step();
        idle();
        step();
        got = sample();
        n_cmp++;
        if (got !== obs_t'{v: 1'b1, d: 8'd255, wr: 1'b1, a: 4'd2, wd: 8'd0}) begin
            n_fail++;
            $display("FAIL clear_rsp: got %h want v=1 d=255 wr=1 a=2 wd=0", got);
        end
        step();
        n_cmp++;
        if ({rsp_valid, rsp_data, ram_wr} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL read_rsp: got rv=%b rd=%0d wr=%b want 1 0 0", rsp_valid, rsp_data, ram_wr);
        end
        step();
    endtask

    task automatic test_mid_reset();
        drive(OP_ADD, 4'd5, 8'd9);
        step();
        drive(OP_ADD, 4'd5, 8'd9);
        step();
        idle();
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, init_done, rsp_valid, ram_wr, rsp_data, ram_waddr} !== {4'b0000, 8'd0, 4'd0}) begin
            n_fail++;
            $display("FAIL mid_rst_async: got rdy=%b done=%b rv=%b wr=%b rd=%0d wa=%0d want all 0",
                     req_ready, init_done, rsp_valid, ram_wr, rsp_data, ram_waddr);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if ({rsp_valid, ram_wr, ram_rd} !== 3'b000) begin
                n_fail++;
                $display("FAIL mid_rst_hold[%0d]: got rv,wr,rd=%b want 000", c, {rsp_valid, ram_wr, ram_rd});
            end
        end
        run_zero_fill("refill");
        // The dropped ADDs must not have touched address 5 after the refill.
        drive(OP_READ, 4'd5, 8'd0);
        step();
        idle();
        step();
        step();
        n_cmp++;
        if ({rsp_valid, rsp_data, ram_wr} !== {1'b1, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL refill_read: got rv=%b rd=%0d wr=%b want 1 0 0", rsp_valid, rsp_data, ram_wr);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_saturation();
        test_mixed_ops();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_rmw_ctrl.md
Name: ram_rmw_ctrl

Overview:
- Read-modify-write engine for a pipelined two-port RAM of statistics counters.
- Accepts update requests, issues RAM reads, and consumes the hazard-corrected read data from the downstream read-refresh stage (ram_rdata_proc).
- Applies the operation and writes the result back, with one request accepted per cycle.
- After reset, zero-fills the whole RAM before accepting requests.

Parameters:
- RAM_PIPE_STAGE, 2, RAM read latency in cycles (ram_rd to ram_rdata_proc valid); must be >= 2
- ADDR_WIDTH, 4, RAM address width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 8, counter/data width

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request valid
- req_ready  output  1  request accepted when req_valid & req_ready
- req_op  input  2  00 ADD, 01 CLEAR, 10 READ, 11 SET
- req_addr  input  ADDR_WIDTH  counter address
- req_data  input  DATA_WIDTH  increment (ADD) or new value (SET); ignored otherwise
- rsp_valid  output  1  one-cycle pulse per accepted request
- rsp_data  output  DATA_WIDTH  value read before modification
- init_done  output  1  high once zero-fill is complete
- ram_rd  output  1  RAM read enable
- ram_raddr  output  ADDR_WIDTH  RAM read address
- ram_wr  output  1  RAM write enable
- ram_waddr  output  ADDR_WIDTH  RAM write address
- ram_wmask  output  DATA_WIDTH  write bit mask; always all ones
- ram_wdata  output  DATA_WIDTH  write data
- ram_rdata_proc  input  DATA_WIDTH  refreshed read data, valid RAM_PIPE_STAGE cycles after ram_rd

Behaviour:
- Reset values: FSM=INIT, init counter=0, pipeline valids=0, req_ready=0, rsp_valid=0, rsp_data=0, init_done=0, ram_wr=0, ram_waddr=0, ram_wdata=0, ram_wmask=all ones.
- Reset is asynchronous and may assert mid-operation: all in-flight operations are dropped, no write or response is emitted for them, and the block restarts in INIT.
- FSM INIT:
  - ram_wr=1, ram_waddr=counter, ram_wdata=0 every cycle; counter increments.
  - After the write of address 2**ADDR_WIDTH-1, go to RUN.
  - Zero-fill takes exactly 2**ADDR_WIDTH cycles.
  - req_ready=0 and ram_rd=0 throughout.
- FSM RUN:
  - init_done=1 and req_ready=1, held permanently; no backpressure.
  - On accept at cycle t: ram_rd=1 and ram_raddr=req_addr combinationally in cycle t. Otherwise ram_rd=0.
- Op pipeline:
  - op, addr and req_data are carried through a RAM_PIPE_STAGE-deep valid-tagged shift pipeline.
  - At cycle t+RAM_PIPE_STAGE, sample ram_rdata_proc as old value D.
  - Result R: ADD = min(D + req_data, 2**DATA_WIDTH-1), computed at DATA_WIDTH+1 bits and saturated; CLEAR = 0; SET = req_data; READ = no write.
- Outputs at cycle t+RAM_PIPE_STAGE+1 (registered):
  - rsp_valid=1, rsp_data=D.
  - For every op except READ: ram_wr=1, ram_waddr=addr, ram_wdata=R.
- Total latency: accept to response/write is RAM_PIPE_STAGE+1 cycles.
- Hazards:
  - Back-to-back or near requests to the same address are legal at full rate; the block performs no stalling.
  - Correctness relies on the refresh stage covering writes in cycles r..r+RAM_PIPE_STAGE for a read issued in cycle r.
  - The write for a request accepted at t lands at t+RAM_PIPE_STAGE+1, which is always inside the window of every later read to that address issued up to that cycle.
  - Same-cycle read and write to the same address is legal.
- rsp_valid and ram_wr are deasserted in idle cycles; rsp_data holds its last value.

Test Plan (RAM_PIPE_STAGE=2, ADDR_WIDTH=4, DATA_WIDTH=8):
- Reset release:
  - ram_wr=1 with waddr 0..15 and wdata 0 over 16 cycles.
  - init_done and req_ready go 1 in cycle 16; no ram_rd before then.
- Single ADD:
  - ADD addr 3 data 5 accepted at t.
  - ram_rd at t.
  - At t+3: rsp_valid=1, rsp_data=0, ram_wr=1, waddr=3, wdata=5.
- Back-to-back ADD addr 7 data 1 for 4 consecutive cycles:
  - rsp_data sequence 0,1,2,3.
  - Final write wdata=4.
  - Proves hazard bypass at full rate.
- Saturation:
  - SET addr 2 = 250, then ADD addr 2 data 10.
  - ADD response rsp_data=250; written value 255.
- Mixed ops:
  - CLEAR addr 2 returns 255 and writes 0.
  - Following READ addr 2 returns 0 with ram_wr=0.
- Mid-operation reset:
  - Assert rst_n=0 with 2 requests in flight.
  - No rsp_valid or ram_wr for them.
  - Zero-fill restarts at waddr 0.
